// File: rtl/jk_modn_counter_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | jk_modn_counter_ctrl_pkg : JK excitation codes, mod-N next-count |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
package jk_modn_counter_ctrl_pkg;

   // bit1 = J, bit0 = K
   typedef logic [1:0] jk_code_t;

   localparam jk_code_t JK_HOLD = 2'b00;
   localparam jk_code_t JK_CLR  = 2'b01;
   localparam jk_code_t JK_SET  = 2'b10;
   localparam jk_code_t JK_TGL  = 2'b11;

   function automatic logic [31:0] next_count(input logic [31:0] cur,
                                              input logic        up,
                                              input logic [31:0] modulo);
      if (up)
         return (cur == modulo - 32'd1) ? 32'd0 : cur + 32'd1;
      else
         return (cur == 32'd0) ? modulo - 32'd1 : cur - 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jk_modn_counter_ctrl_jk_bank.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | jk_modn_counter_ctrl_jk_bank : WIDTH JK flip-flops, no reset     |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module jk_modn_counter_ctrl_jk_bank
   import jk_modn_counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] j_vec,
   input  logic [WIDTH-1:0] k_vec,
   output logic [WIDTH-1:0] q
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic q_bit;

      always_ff @(posedge clk) begin
         case (jk_code_t'({j_vec[i], k_vec[i]}))
            JK_SET:  q_bit <= 1'b1;
            JK_CLR:  q_bit <= 1'b0;
            JK_TGL:  q_bit <= ~q_bit;
            default: q_bit <= q_bit;
         endcase
      end

      assign q[i] = q_bit;
   end

endmodule
`default_nettype wire

// File: rtl/jk_modn_counter_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | jk_modn_counter_ctrl : mod-N up/down counter built on a JK bank  |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module jk_modn_counter_ctrl
   import jk_modn_counter_ctrl_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int MODULO = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             load_err,
   output logic             illegal,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec
);

   // One extra bit so MODULO == 2**WIDTH still compares correctly
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] diff;
   logic             load_ok;
   jk_code_t [WIDTH-1:0] code;

   jk_modn_counter_ctrl_jk_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk   (clk),
      .j_vec (j_vec),
      .k_vec (k_vec),
      .q     (q)
   );

   assign count   = q;
   assign illegal = ({1'b0, q} >= MOD_EXT);
   assign load_ok = ({1'b0, load_val} < MOD_EXT);
   assign nxt     = WIDTH'(next_count(32'(q), up, 32'(MODULO)));
   assign diff    = q ^ nxt;

   assign tc = en & ~load & ~rst & ~illegal &
               (up ? (q == MAX_COUNT) : (q == '0));

   always_comb begin
      code  = '0;
      j_vec = '0;
      k_vec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (rst)
            code[i] = JK_CLR;
         else if (load)
            code[i] = (load_ok && load_val[i]) ? JK_SET : JK_CLR;
         else if (illegal)
            code[i] = JK_CLR;
         else if (en && diff[i])
            code[i] = JK_TGL;
         else
            code[i] = JK_HOLD;
         j_vec[i] = code[i][1];
         k_vec[i] = code[i][0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         load_err <= 1'b0;
      else if (load)
         load_err <= ~load_ok;
   end

endmodule
`default_nettype wire

// File: tb/tb_jk_modn_counter_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_jk_modn_counter_ctrl : scoreboard bench with reference model  |
// | Revision 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_jk_modn_counter_ctrl;

   localparam int WIDTH  = 3;
   localparam int MODULO = 7;
   localparam logic [WIDTH-1:0] ONES = '1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic             up = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             load_err;
   logic             illegal;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;

   jk_modn_counter_ctrl #(
      .WIDTH  (WIDTH),
      .MODULO (MODULO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .load_err (load_err),
      .illegal  (illegal),
      .j_vec    (j_vec),
      .k_vec    (k_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               full;
      logic [WIDTH-1:0] count;
      logic             tc;
      logic             load_err;
      logic             illegal;
      logic [WIDTH-1:0] j;
      logic [WIDTH-1:0] k;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state: plain integer count and the error flag
   int m_count = 0;
   bit m_err   = 1'b0;

   task automatic step(input bit r, input bit e, input bit u, input bit l,
                       input int lv, input bit full);
      exp_t x;
      int   nxt;
      bit   ill;
      @(posedge clk);
      #1;
      rst      = r;
      en       = e;
      up       = u;
      load     = l;
      load_val = WIDTH'(lv);
      ill = (m_count >= MODULO);
      x.full     = full;
      x.count    = WIDTH'(m_count);
      x.illegal  = ill;
      x.load_err = m_err;
      x.tc       = e && !l && !r && !ill &&
                   (u ? (m_count == MODULO - 1) : (m_count == 0));
      if (r)        nxt = 0;
      else if (l)   nxt = (lv < MODULO) ? lv : 0;
      else if (ill) nxt = 0;
      else if (e)   nxt = u ? (m_count + 1) % MODULO : (m_count + MODULO - 1) % MODULO;
      else          nxt = m_count;
      if (r || ill && !l || l && lv >= MODULO) begin
         x.j = '0;
         x.k = ONES;
      end else if (l) begin
         x.j = WIDTH'(lv);
         x.k = ~WIDTH'(lv);
      end else if (e) begin
         x.j = WIDTH'(m_count ^ nxt);
         x.k = WIDTH'(m_count ^ nxt);
      end else begin
         x.j = '0;
         x.k = '0;
      end
      if (r)      m_err = 1'b0;
      else if (l) m_err = (lv >= MODULO);
      m_count = nxt;
      exp_q.push_back(x);
   endtask

   // Drive the bank to an out-of-range value without a reset; the stored
   // flop value is 0 beforehand, so the next count is 0 either way.
   task automatic force_illegal(input int val);
      exp_t x;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      en   = 1'b0;
      load = 1'b0;
      force dut.q = WIDTH'(val);
      x.full     = 1'b1;
      x.count    = WIDTH'(val);
      x.illegal  = 1'b1;
      x.tc       = 1'b0;
      x.load_err = m_err;
      x.j        = '0;
      x.k        = ONES;
      m_count    = 0;
      exp_q.push_back(x);
      @(negedge clk);
      #1;
      release dut.q;
   endtask

   initial begin : monitor
      exp_t x;
      bit   bad;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (x.full)
               bad = (count !== x.count) || (tc !== x.tc) || (load_err !== x.load_err) ||
                     (illegal !== x.illegal) || (j_vec !== x.j) || (k_vec !== x.k);
            else
               bad = (tc !== x.tc) || (j_vec !== x.j) || (k_vec !== x.k);
            if (bad) begin
               miscompares++;
               $display("FAIL vec %0d: count=%0d/%0d tc=%0b/%0b load_err=%0b/%0b illegal=%0b/%0b j=%b/%b k=%b/%b (actual/required)",
                        vectors, count, x.count, tc, x.tc, load_err, x.load_err,
                        illegal, x.illegal, j_vec, x.j, k_vec, x.k);
            end
         end
      end
   end

   initial begin : driver
      // Bank is uninitialised: only excitation and tc are known during rst
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1);
      step(0, 1, 1, 1, 5, 1);
      step(0, 1, 1, 1, 7, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      force_illegal(7);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 3, 1);
      step(1, 1, 1, 1, 4, 1);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 7)), 1);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
